// File: rtl/div_config_loader.sv
// div_config_loader: loads a divisor word serially (MSB first), checks it,
// and hands it to a frequency divider through Din with a one-cycle ConfigDiv
// strobe, then enables the divider while in RUN.
//
// Optional feature macro: PARITY_CHECK_EN. When it is defined, WIDTH+1 bits
// are accepted and the last one is an even-parity bit over the data bits.
//
// Serial handshake: there is no ready signal. A bit is accepted on every
// rising edge where the FSM is in SHIFT, SerValid=1 and Start=0. SerValid
// in any other state is ignored.
//
// fsm_state exposes the state register for debug:
//   0=IDLE 1=SHIFT 2=CHECK 3=LOAD 4=RUN
module div_config_loader #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             SerData,
  input  logic             SerValid,
  input  logic             Run,
  output logic [WIDTH-1:0] Din,
  output logic             ConfigDiv,
  output logic             Enable,
  output logic             Busy,
  output logic             Done,
  output logic             Error,
  output logic [2:0]       fsm_state
);

`ifdef PARITY_CHECK_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    LOAD  = 3'd3,
    RUN   = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [NBITS-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] data_word;
  logic             load_bad;
  logic             start_new;
  logic             accept_bit;
  logic             last_bit;

  logic [WIDTH-1:0] din_nxt;
  logic             config_div_nxt;
  logic             enable_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             error_nxt;

  // Data bits sit above the parity bit when parity is compiled in.
`ifdef PARITY_CHECK_EN
  assign data_word = shift_reg[NBITS-1:1];
  assign load_bad  = (data_word == '0) || (^shift_reg);
`else
  assign data_word = shift_reg;
  assign load_bad  = (data_word == '0);
`endif

  // Start clears and (re)starts a load from IDLE, RUN or SHIFT.
  assign start_new  = Start && (state == IDLE || state == RUN || state == SHIFT);
  assign accept_bit = (state == SHIFT) && SerValid && !Start;
  assign last_bit   = accept_bit && (bit_cnt == CW'(NBITS - 1));

  assign fsm_state = state;

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = SHIFT;
      SHIFT:   if (Start) next_state = SHIFT;
               else if (last_bit) next_state = CHECK;
      CHECK:   next_state = load_bad ? IDLE : LOAD;
      LOAD:    next_state = RUN;
      RUN:     if (Start) next_state = SHIFT;
      default: next_state = IDLE;
    endcase
  end

  // Shift register and bit counter; the counter never wraps because SHIFT is
  // left on the edge that accepts the final bit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (start_new) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (accept_bit) begin
      shift_reg <= {shift_reg[NBITS-2:0], SerData};
      bit_cnt   <= bit_cnt + CW'(1);
    end
  end

  // Output next values, derived from the state being entered.
  always_comb begin
    din_nxt        = Din;
    config_div_nxt = (next_state == LOAD);
    enable_nxt     = (next_state == RUN) && Run;
    busy_nxt       = (next_state == SHIFT) || (next_state == CHECK) ||
                     (next_state == LOAD);
    done_nxt       = (state == LOAD);
    error_nxt      = Error;
    if (next_state == LOAD) din_nxt = data_word;
    if (state == CHECK && load_bad) error_nxt = 1'b1;
    else if (Start && (state == IDLE || state == RUN)) error_nxt = 1'b0;
  end

  // Output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Din       <= '0;
      ConfigDiv <= 1'b0;
      Enable    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      Din       <= din_nxt;
      ConfigDiv <= config_div_nxt;
      Enable    <= enable_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
      Error     <= error_nxt;
    end
  end

endmodule

// File: tb/tb_div_config_loader.sv
// Testbench for div_config_loader: directed scenarios plus randomized loads,
// checked against a word-level model of the loader's behaviour.
module tb_div_config_loader;

  localparam int W = 32;
`ifdef PARITY_CHECK_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Start = 1'b0;
  logic         SerData = 1'b0;
  logic         SerValid = 1'b0;
  logic         Run = 1'b0;
  logic [W-1:0] Din;
  logic         ConfigDiv, Enable, Busy, Done, Error;
  logic [2:0]   fsm_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_din = '0;

  div_config_loader #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .SerData(SerData),
    .SerValid(SerValid), .Run(Run), .Din(Din), .ConfigDiv(ConfigDiv),
    .Enable(Enable), .Busy(Busy), .Done(Done), .Error(Error),
    .fsm_state(fsm_state)
  );

  // Clock generation.
  always #5 Clk = ~Clk;

  // Advance one clock and settle; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    n_checks++;
    if ({Din, ConfigDiv, Enable, Busy, Done, Error, fsm_state} !== '0) begin
      $display("FAIL reset_outputs: got Din=%h cfg=%b en=%b busy=%b done=%b err=%b st=%0d, want all 0",
               Din, ConfigDiv, Enable, Busy, Done, Error, fsm_state);
      n_fail++;
    end
    Reset = 1'b0;
    exp_din = '0;
  endtask

  // Full load of one word. gap_mode: 0 none, 1 idle cycle before every bit,
  // 2 random 0..2 idle cycles. junk: bits sent before a restarting Start.
  task automatic send_load(input logic [W-1:0] word, input bit flip_par,
                           input int gap_mode, input logic run_val, input int junk);
    logic [NB-1:0] bits;
    int ones;
    bit good;
    int gaps;
    ones = 0;
    for (int i = 0; i < W; i++) if (word[i]) ones++;
`ifdef PARITY_CHECK_EN
    bits = {word, 1'((ones % 2) == 1) ^ 1'(flip_par)};
    good = (word != 0) && !flip_par;
`else
    bits = word;
    good = (word != 0);
`endif
    Run = run_val;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n_checks++;
    if (fsm_state !== S_SHIFT || Busy !== 1'b1 || Enable !== 1'b0 || Error !== 1'b0 || Din !== exp_din) begin
      $display("FAIL start_entry: st=%0d busy=%b en=%b err=%b Din=%h, want st=1 busy=1 en=0 err=0 Din=%h",
               fsm_state, Busy, Enable, Error, Din, exp_din);
      n_fail++;
    end
    if (junk > 0) begin
      for (int j = 0; j < junk; j++) begin
        SerValid = 1'b1;
        SerData = 1'($urandom_range(0, 1));
        tick();
      end
      SerValid = 1'b0;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      n_checks++;
      if (fsm_state !== S_SHIFT || Busy !== 1'b1) begin
        $display("FAIL restart_in_shift: st=%0d busy=%b, want st=1 busy=1", fsm_state, Busy);
        n_fail++;
      end
    end
    for (int i = NB - 1; i >= 0; i--) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        SerValid = 1'b0;
        SerData = 1'($urandom_range(0, 1));
        tick();
      end
      if (i == 0) begin
        n_checks++;
        if (fsm_state !== S_SHIFT || ConfigDiv !== 1'b0) begin
          $display("FAIL before_last_bit: st=%0d cfg=%b, want st=1 cfg=0", fsm_state, ConfigDiv);
          n_fail++;
        end
      end
      SerValid = 1'b1;
      SerData = bits[i];
      tick();
    end
    // Extra valid bits after the final one must be ignored.
    SerValid = 1'($urandom_range(0, 1));
    SerData = 1'($urandom_range(0, 1));
    n_checks++;
    if (fsm_state !== S_CHECK || Busy !== 1'b1 || ConfigDiv !== 1'b0) begin
      $display("FAIL check_cycle_n1: st=%0d busy=%b cfg=%b, want st=2 busy=1 cfg=0", fsm_state, Busy, ConfigDiv);
      n_fail++;
    end
    tick();
    SerValid = 1'b0;
    if (good) begin
      exp_din = word;
      n_checks++;
      if (fsm_state !== S_LOAD || ConfigDiv !== 1'b1 || Din !== word || Enable !== 1'b0 || Busy !== 1'b1) begin
        $display("FAIL load_cycle_n2: st=%0d cfg=%b Din=%h en=%b busy=%b, want st=3 cfg=1 Din=%h en=0 busy=1",
                 fsm_state, ConfigDiv, Din, Enable, Busy, word);
        n_fail++;
      end
      tick();
      n_checks++;
      if (fsm_state !== S_RUN || Done !== 1'b1 || Enable !== run_val || Busy !== 1'b0 || ConfigDiv !== 1'b0) begin
        $display("FAIL run_cycle_n3: st=%0d done=%b en=%b busy=%b cfg=%b, want st=4 done=1 en=%b busy=0 cfg=0",
                 fsm_state, Done, Enable, Busy, ConfigDiv, run_val);
        n_fail++;
      end
      tick();
      n_checks++;
      if (Done !== 1'b0 || Din !== exp_din || Enable !== run_val || Error !== 1'b0) begin
        $display("FAIL run_cycle_n4: done=%b Din=%h en=%b err=%b, want done=0 Din=%h en=%b err=0",
                 Done, Din, Enable, Error, exp_din, run_val);
        n_fail++;
      end
    end else begin
      n_checks++;
      if (fsm_state !== S_IDLE || Error !== 1'b1 || Din !== exp_din || ConfigDiv !== 1'b0 || Busy !== 1'b0) begin
        $display("FAIL reject_n2: st=%0d err=%b Din=%h cfg=%b busy=%b, want st=0 err=1 Din=%h cfg=0 busy=0",
                 fsm_state, Error, Din, ConfigDiv, Busy, exp_din);
        n_fail++;
      end
      tick();
      n_checks++;
      if (Error !== 1'b1 || ConfigDiv !== 1'b0 || Done !== 1'b0 || Enable !== 1'b0) begin
        $display("FAIL reject_sticky: err=%b cfg=%b done=%b en=%b, want err=1 cfg=0 done=0 en=0",
                 Error, ConfigDiv, Done, Enable);
        n_fail++;
      end
    end
  endtask

  task automatic test_basic();
    send_load(32'h0000_0005, 1'b0, 0, 1'b1, 0);
  endtask

  task automatic test_zero_word();
    send_load(32'h0000_0000, 1'b0, 0, 1'b1, 0);
  endtask

  task automatic test_parity();
`ifdef PARITY_CHECK_EN
    send_load(32'h0000_0003, 1'b1, 0, 1'b1, 0);
    send_load(32'h0000_0003, 1'b0, 0, 1'b1, 0);
`endif
  endtask

  task automatic test_gapped_valid();
    send_load(32'hA5A5_A5A5, 1'b0, 1, 1'b1, 0);
  endtask

  // Start from RUN with Enable=1; send_load itself checks the drop of Enable,
  // Busy=1 and the held Din on the first SHIFT cycle.
  task automatic test_restart_from_run();
    n_checks++;
    if (fsm_state !== S_RUN || Enable !== 1'b1) begin
      $display("FAIL run_before_restart: st=%0d en=%b, want st=4 en=1", fsm_state, Enable);
      n_fail++;
    end
    send_load(32'h1234_5678, 1'b0, 2, 1'b1, 3);
  endtask

  task automatic test_ignore_outside_shift();
    logic [2:0] st0;
    st0 = fsm_state;
    for (int i = 0; i < 5; i++) begin
      SerValid = 1'b1;
      SerData = 1'($urandom_range(0, 1));
      tick();
    end
    SerValid = 1'b0;
    n_checks++;
    if (fsm_state !== st0 || Busy !== 1'b0 || Din !== exp_din || ConfigDiv !== 1'b0) begin
      $display("FAIL ignore_outside: st=%0d busy=%b Din=%h cfg=%b, want st=%0d busy=0 Din=%h cfg=0",
               fsm_state, Busy, Din, ConfigDiv, st0, exp_din);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_load();
    Run = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      SerValid = 1'b1;
      SerData = 1'($urandom_range(0, 1));
      tick();
    end
    SerValid = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    n_checks++;
    if ({Din, ConfigDiv, Enable, Busy, Done, Error, fsm_state} !== '0) begin
      $display("FAIL reset_mid_immediate: Din=%h cfg=%b en=%b busy=%b done=%b err=%b st=%0d, want all 0",
               Din, ConfigDiv, Enable, Busy, Done, Error, fsm_state);
      n_fail++;
    end
    tick();
    n_checks++;
    if ({Din, ConfigDiv, Enable, Busy, Done, Error, fsm_state} !== '0) begin
      $display("FAIL reset_mid_held: Din=%h cfg=%b en=%b busy=%b done=%b err=%b st=%0d, want all 0",
               Din, ConfigDiv, Enable, Busy, Done, Error, fsm_state);
      n_fail++;
    end
    Reset = 1'b0;
    exp_din = '0;
    send_load(32'h0000_0007, 1'b0, 0, 1'b1, 0);
  endtask

  task automatic test_random_loads();
    logic [W-1:0] word;
    for (int k = 0; k < 10; k++) begin
      word = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      send_load(word, bit'($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 1)) * int'($urandom_range(1, 4)));
      if ($urandom_range(0, 1) == 1) test_ignore_outside_shift();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_word();
    test_parity();
    test_gapped_valid();
    test_restart_from_run();
    test_ignore_outside_shift();
    test_reset_mid_load();
    test_random_loads();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
